// File: rtl/multi_trigger_edge_ctrl.sv
// Multi-channel trigger conditioner: synchroniser, glitch filter,
// edge qualification, holdoff, and toggle/pulse output per channel.
module multi_trigger_edge_ctrl #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [CH_NUM-1:0]     Trig_Ain,
  input  logic [CH_NUM-1:0]     NTrig_EN,
  input  logic [2*CH_NUM-1:0]   Edge_Mode,
  input  logic [CH_NUM-1:0]     Out_Mode,
  input  logic [FILT_W-1:0]     Filt_Len,
  input  logic [HOLD_W-1:0]     Holdoff_Len,
  output logic [CH_NUM-1:0]     Trig_Dout,
  output logic [CH_NUM-1:0]     Trig_Evt,
  output logic [CH_NUM-1:0]     Busy
);

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } state_t;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_out;
    logic                   filt_q;
    logic [FILT_W-1:0]      fcnt_q;
    logic [HOLD_W-1:0]      hcnt_q;
    state_t                 state_q;
    logic                   dout_q;
    logic                   evt_q;
    logic                   busy_q;
    logic                   commit;
    logic                   evt;
    logic                   accept;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], Trig_Ain[g]};
      end
    end

    assign s_out = sync_q[SYNC_STAGES-1];

    // >= keeps the counter from running away if Filt_Len shrinks live
    assign commit = (s_out != filt_q) && (fcnt_q >= Filt_Len);
    assign evt    = commit &&
                    (s_out ? Edge_Mode[2*g] : Edge_Mode[2*g+1]);
    assign accept = evt && (state_q == ARMED);

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        filt_q <= 1'b0;
        fcnt_q <= '0;
      end else if (!NTrig_EN[g]) begin
        filt_q <= 1'b0;
        fcnt_q <= '0;
      end else if (s_out == filt_q) begin
        fcnt_q <= '0;
      end else if (commit) begin
        filt_q <= s_out;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FILT_W'(1);
      end
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        state_q <= ARMED;
        hcnt_q  <= '0;
        dout_q  <= 1'b0;
        evt_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (!NTrig_EN[g]) begin
        state_q <= ARMED;
        hcnt_q  <= '0;
        dout_q  <= 1'b0;
        evt_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        evt_q  <= accept;
        dout_q <= Out_Mode[g] ? accept : (dout_q ^ accept);
        unique case (state_q)
          ARMED: begin
            if (accept && (Holdoff_Len != '0)) begin
              hcnt_q  <= Holdoff_Len;
              state_q <= HOLD;
              busy_q  <= 1'b1;
            end
          end
          HOLD: begin
            if (hcnt_q <= HOLD_W'(1)) begin
              hcnt_q  <= '0;
              state_q <= ARMED;
              busy_q  <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q - HOLD_W'(1);
            end
          end
        endcase
      end
    end

    assign Trig_Dout[g] = dout_q;
    assign Trig_Evt[g]  = evt_q;
    assign Busy[g]      = busy_q;
  end

endmodule

// File: tb/tb_multi_trigger_edge_ctrl.sv
// Scoreboard bench for multi_trigger_edge_ctrl: expected accepts are
// queued with their arrival cycle and output level, then matched.
module tb_multi_trigger_edge_ctrl;
  localparam int CH = 4;

  logic          Clock       = 1'b0;
  logic          Reset       = 1'b1;
  logic [CH-1:0] Trig_Ain    = '0;
  logic [CH-1:0] NTrig_EN    = '1;
  logic [2*CH-1:0] Edge_Mode = '0;
  logic [CH-1:0] Out_Mode    = '0;
  logic [7:0]    Filt_Len    = '0;
  logic [15:0]   Holdoff_Len = '0;
  logic [CH-1:0] Trig_Dout;
  logic [CH-1:0] Trig_Evt;
  logic [CH-1:0] Busy;

  multi_trigger_edge_ctrl #(
    .CH_NUM(CH), .SYNC_STAGES(2), .FILT_W(8), .HOLD_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Trig_Ain(Trig_Ain),
    .NTrig_EN(NTrig_EN), .Edge_Mode(Edge_Mode),
    .Out_Mode(Out_Mode), .Filt_Len(Filt_Len),
    .Holdoff_Len(Holdoff_Len), .Trig_Dout(Trig_Dout),
    .Trig_Evt(Trig_Evt), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   ch;
    logic dout;
  } exp_t;

  exp_t sb[$];
  logic tog[CH];
  int   checks   = 0;
  int   failures = 0;

  logic cnt_en    = 1'b0;
  int   busy_cnt  = 0;
  int   pulse_cnt = 0;

  always @(negedge Clock) begin
    if (cnt_en) begin
      busy_cnt  += int'(Busy[3]);
      pulse_cnt += int'(Trig_Dout[3]);
    end
  end

  // Match every strobe against the queue; stale entries are misses
  always @(negedge Clock) begin
    int idx;
    for (int c = 0; c < CH; c++) begin
      if (Trig_Evt[c]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].ch == c && sb[i].cyc == cyc) idx = i;
        checks++;
        if (idx < 0) begin
          failures++;
          $display("FAIL evt_unexpected ch%0d cyc=%0d got=1 want=0",
                   c, cyc);
        end else begin
          if (Trig_Dout[c] !== sb[idx].dout) begin
            failures++;
            $display("FAIL evt_dout ch%0d cyc=%0d got=%b want=%b",
                     c, cyc, Trig_Dout[c], sb[idx].dout);
          end
          sb.delete(idx);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        failures++;
        $display("FAIL evt_missed ch%0d got=none want_cyc=%0d",
                 sb[i].ch, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push(input int c, input int lat);
    exp_t e;
    e.ch  = c;
    e.cyc = cyc + lat;
    if (Out_Mode[c]) begin
      e.dout = 1'b1;
    end else begin
      tog[c] = ~tog[c];
      e.dout = tog[c];
    end
    sb.push_back(e);
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    Edge_Mode[2*c +: 2] = m;
  endtask

  task automatic test_reset();
    for (int c = 0; c < CH; c++) tog[c] = 1'b0;
    tick(3);
    checks++;
    if (Trig_Dout !== '0 || Trig_Evt !== '0 || Busy !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b/%b want=0/0/0",
               Trig_Dout, Trig_Evt, Busy);
    end
    Trig_Ain[0] = 1'b1;
    set_mode(0, 2'b01);
    Holdoff_Len = 16'd50;
    Reset = 1'b0;
    push(0, 3);
    tick(5);
    checks++;
    if (Busy[0] !== 1'b1 || Trig_Dout[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_accept got busy=%b dout=%b want 1 1",
               Busy[0], Trig_Dout[0]);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Trig_Dout !== '0 || Busy !== '0 || Trig_Evt !== '0) begin
      failures++;
      $display("FAIL reset_async got=%b/%b/%b want=0/0/0",
               Trig_Dout, Busy, Trig_Evt);
    end
    tog[0] = 1'b0;
    Trig_Ain = '0;
    tick(1);
    Reset = 1'b0;
    Holdoff_Len = '0;
    tick(10);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_sb_empty got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_falling_toggle();
    Edge_Mode = '0;
    set_mode(0, 2'b10);
    Trig_Ain[0] = 1'b1;
    tick(10);
    for (int k = 0; k < 3; k++) begin
      Trig_Ain[0] = 1'b0;
      push(0, 3);
      tick(10);
      Trig_Ain[0] = 1'b1;
      tick(10);
    end
    checks++;
    if (Trig_Dout[0] !== 1'b1) begin
      failures++;
      $display("FAIL fall_final_dout got=%b want=1", Trig_Dout[0]);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL fall_sb_empty got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_glitch();
    Edge_Mode = '0;
    set_mode(2, 2'b11);
    Filt_Len = 8'd3;
    tick(5);
    Trig_Ain[2] = 1'b1;
    tick(3);
    Trig_Ain[2] = 1'b0;
    tick(15);
    Trig_Ain[2] = 1'b1;
    push(2, 6);
    tick(4);
    Trig_Ain[2] = 1'b0;
    push(2, 6);
    tick(15);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL glitch_sb_empty got=%0d want=0", sb.size());
    end
    checks++;
    if (Trig_Dout[2] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_dout got=%b want=0", Trig_Dout[2]);
    end
    Filt_Len = '0;
  endtask

  task automatic test_holdoff();
    Edge_Mode = '0;
    set_mode(3, 2'b01);
    Out_Mode[3] = 1'b1;
    Holdoff_Len = 16'd10;
    tick(3);
    cnt_en = 1'b1;
    Trig_Ain[3] = 1'b1;
    push(3, 3);
    tick(2);
    Trig_Ain[3] = 1'b0;
    tick(3);
    Trig_Ain[3] = 1'b1;
    tick(2);
    Trig_Ain[3] = 1'b0;
    tick(10);
    Trig_Ain[3] = 1'b1;
    push(3, 3);
    tick(2);
    Trig_Ain[3] = 1'b0;
    tick(20);
    cnt_en = 1'b0;
    checks++;
    if (busy_cnt != 20) begin
      failures++;
      $display("FAIL hold_busy_cycles got=%0d want=20", busy_cnt);
    end
    checks++;
    if (pulse_cnt != 2) begin
      failures++;
      $display("FAIL hold_pulse_cycles got=%0d want=2", pulse_cnt);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL hold_sb_empty got=%0d want=0", sb.size());
    end
    Holdoff_Len = '0;
    Out_Mode[3] = 1'b0;
  endtask

  task automatic test_enable();
    Edge_Mode = '0;
    set_mode(1, 2'b01);
    Trig_Ain[1] = 1'b1;
    push(1, 3);
    tick(6);
    checks++;
    if (Trig_Dout[1] !== 1'b1) begin
      failures++;
      $display("FAIL en_pre_dout got=%b want=1", Trig_Dout[1]);
    end
    NTrig_EN[1] = 1'b0;
    tog[1] = 1'b0;
    tick(1);
    checks++;
    if (Trig_Dout[1] !== 1'b0 || Busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL en_cleared got dout=%b busy=%b want 0 0",
               Trig_Dout[1], Busy[1]);
    end
    checks++;
    if (Trig_Dout[0] !== tog[0] || Trig_Dout[2] !== tog[2]) begin
      failures++;
      $display("FAIL en_others got=%b%b want=%b%b",
               Trig_Dout[2], Trig_Dout[0], tog[2], tog[0]);
    end
    NTrig_EN[1] = 1'b1;
    push(1, 1);
    tick(5);
    NTrig_EN[1] = 1'b0;
    tog[1] = 1'b0;
    tick(2);
    Trig_Ain[1] = 1'b0;
    tick(3);
    Trig_Ain[1] = 1'b1;
    tick(3);
    Trig_Ain[1] = 1'b0;
    tick(4);
    NTrig_EN[1] = 1'b1;
    tick(8);
    checks++;
    if (Trig_Dout[1] !== 1'b0) begin
      failures++;
      $display("FAIL en_disabled_edges got=%b want=0", Trig_Dout[1]);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL en_sb_empty got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_simultaneous();
    Edge_Mode = '0;
    Trig_Ain  = '0;
    tick(10);
    set_mode(0, 2'b01);
    set_mode(1, 2'b10);
    set_mode(2, 2'b11);
    set_mode(3, 2'b00);
    Out_Mode = 4'b1100;
    tick(2);
    Trig_Ain = '1;
    push(0, 3);
    push(2, 3);
    tick(10);
    Trig_Ain = '0;
    push(1, 3);
    push(2, 3);
    tick(10);
    checks++;
    if (Trig_Dout !== {2'b00, tog[1], tog[0]}) begin
      failures++;
      $display("FAIL simul_dout got=%b want=%b", Trig_Dout,
               {2'b00, tog[1], tog[0]});
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL simul_sb_empty got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_falling_toggle();
    test_glitch();
    test_holdoff();
    test_enable();
    test_simultaneous();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
